// File: rtl/oifs_tx_scheduler.sv
// Two-requester scheduler for the shared opto-isolated fast-serial TX interface:
// one-word holding register per channel, fixed-priority A with a B starvation limit, and the bit-rate tick.
module oifs_tx_scheduler #(
  parameter int DATA_W    = 8,
  parameter int TICK_DIV  = 4,
  parameter int MAX_BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_arst,
  input  logic              i_en,
  input  logic              i_a_valid,
  input  logic [DATA_W-1:0] i_a_data,
  output logic              o_a_ready,
  input  logic              i_b_valid,
  input  logic [DATA_W-1:0] i_b_data,
  output logic              o_b_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_channel,
  input  logic              i_ready,
  output logic              o_tick
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);

  // Consecutive-A count only ever needs to reach the limit, so it sticks there.
  function automatic logic [BURST_W-1:0] burst_sat_inc(input logic [BURST_W-1:0] cnt);
    return (cnt == BURST_MAX) ? BURST_MAX : cnt + BURST_W'(1);
  endfunction

  logic              a_full_q, a_full_d;
  logic              b_full_q, b_full_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              chan_q, chan_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;

  logic a_capture, b_capture, free, load, grant_b;

  always_comb begin
    a_capture = i_a_valid & ~a_full_q;
    b_capture = i_b_valid & ~b_full_q;
    free      = ~valid_q | i_ready;
    load      = free & (a_full_q | b_full_q);
    grant_b   = b_full_q & (~a_full_q | (burst_q == BURST_MAX));

    a_full_d = a_full_q;
    b_full_d = b_full_q;
    a_data_d = a_data_q;
    b_data_d = b_data_q;
    valid_d  = valid_q;
    data_d   = data_q;
    chan_d   = chan_q;
    burst_d  = burst_q;

    // A holding reg is only captured when empty and only drained when full,
    // so capture and drain never collide on the same edge.
    if (a_capture) begin
      a_full_d = 1'b1;
      a_data_d = i_a_data;
    end
    if (b_capture) begin
      b_full_d = 1'b1;
      b_data_d = i_b_data;
    end

    if (load) begin
      valid_d = 1'b1;
      if (grant_b) begin
        data_d   = b_data_q;
        chan_d   = 1'b1;
        b_full_d = 1'b0;
        burst_d  = '0;
      end else begin
        data_d   = a_data_q;
        chan_d   = 1'b0;
        a_full_d = 1'b0;
        burst_d  = b_full_q ? burst_sat_inc(burst_q) : '0;
      end
    end else if (free) begin
      valid_d = 1'b0;
    end

    if (!i_en) begin
      tick_cnt_d = '0;
    end else if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      a_full_q   <= 1'b0;
      b_full_q   <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      chan_q     <= 1'b0;
      burst_q    <= '0;
      tick_cnt_q <= '0;
    end else begin
      a_full_q   <= a_full_d;
      b_full_q   <= b_full_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      chan_q     <= chan_d;
      burst_q    <= burst_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Holding payloads are qualified by the full flags, so they need no reset.
  always_ff @(posedge i_clk) begin
    a_data_q <= a_data_d;
    b_data_q <= b_data_d;
  end

  assign o_a_ready = ~a_full_q;
  assign o_b_ready = ~b_full_q;
  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_channel = chan_q;
  assign o_tick    = i_en & (tick_cnt_q == TICK_LAST);

endmodule

// File: tb/tb_oifs_tx_scheduler.sv
// Directed bench for oifs_tx_scheduler: per-cycle vector table plus tick and reset sequences.
module tb_oifs_tx_scheduler;

  logic       i_clk = 1'b0;
  logic       i_arst;
  logic       i_en;
  logic       i_a_valid;
  logic [7:0] i_a_data;
  logic       o_a_ready;
  logic       i_b_valid;
  logic [7:0] i_b_data;
  logic       o_b_ready;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_channel;
  logic       i_ready;
  logic       o_tick;

  int n_tests = 0;
  int n_fail  = 0;

  oifs_tx_scheduler #(.DATA_W(8), .TICK_DIV(4), .MAX_BURST(4)) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_en(i_en),
    .i_a_valid(i_a_valid), .i_a_data(i_a_data), .o_a_ready(o_a_ready),
    .i_b_valid(i_b_valid), .i_b_data(i_b_data), .o_b_ready(o_b_ready),
    .o_valid(o_valid), .o_data(o_data), .o_channel(o_channel),
    .i_ready(i_ready), .o_tick(o_tick)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       a_v;
    logic [7:0] a_d;
    logic       b_v;
    logic [7:0] b_d;
    logic       rdy;
    logic       e_v;
    logic [7:0] e_d;
    logic       e_ch;
    logic       e_ar;
    logic       e_br;
  } vec_t;

  localparam int NV = 32;
  vec_t vt[NV];

  function automatic vec_t mk(input logic a_v, input logic [7:0] a_d, input logic b_v,
                              input logic [7:0] b_d, input logic rdy, input logic e_v,
                              input logic [7:0] e_d, input logic e_ch, input logic e_ar,
                              input logic e_br);
    vec_t v;
    v.a_v = a_v; v.a_d = a_d; v.b_v = b_v; v.b_d = b_d; v.rdy = rdy;
    v.e_v = e_v; v.e_d = e_d; v.e_ch = e_ch; v.e_ar = e_ar; v.e_br = e_br;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    // a_v a_d  b_v b_d  rdy | e_v e_d  ch ar br
    vt[0]  = mk(1, 8'h5A, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1);
    vt[1]  = mk(0, 8'h00, 0, 8'h00, 1, 1, 8'h5A, 0, 1, 1);
    vt[2]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 1, 1);
    vt[3]  = mk(0, 8'h00, 1, 8'h11, 0, 0, 8'h00, 0, 1, 0);
    vt[4]  = mk(0, 8'h00, 1, 8'h22, 0, 1, 8'h11, 1, 1, 1);
    vt[5]  = mk(0, 8'h00, 1, 8'h22, 0, 1, 8'h11, 1, 1, 0);
    for (int i = 6; i <= 12; i++) vt[i] = mk(0, 8'h00, 0, 8'h00, 0, 1, 8'h11, 1, 1, 0);
    vt[13] = mk(0, 8'h00, 0, 8'h00, 1, 1, 8'h22, 1, 1, 1);
    vt[14] = mk(1, 8'h33, 1, 8'h44, 0, 1, 8'h22, 1, 0, 0);
    vt[15] = mk(0, 8'h00, 0, 8'h00, 1, 1, 8'h33, 0, 1, 0);
    vt[16] = mk(0, 8'h00, 0, 8'h00, 1, 1, 8'h44, 1, 1, 1);
    vt[17] = mk(0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 1, 1);
    vt[18] = mk(1, 8'hA1, 1, 8'hB1, 0, 0, 8'h00, 0, 0, 0);
    vt[19] = mk(1, 8'hA1, 1, 8'hB1, 1, 1, 8'hA1, 0, 1, 0);
    vt[20] = mk(1, 8'hA2, 1, 8'hB1, 0, 1, 8'hA1, 0, 0, 0);
    vt[21] = mk(1, 8'hA2, 1, 8'hB1, 1, 1, 8'hA2, 0, 1, 0);
    vt[22] = mk(1, 8'hA3, 1, 8'hB1, 0, 1, 8'hA2, 0, 0, 0);
    vt[23] = mk(1, 8'hA3, 1, 8'hB1, 1, 1, 8'hA3, 0, 1, 0);
    vt[24] = mk(1, 8'hA4, 1, 8'hB1, 0, 1, 8'hA3, 0, 0, 0);
    vt[25] = mk(1, 8'hA4, 1, 8'hB1, 1, 1, 8'hA4, 0, 1, 0);
    vt[26] = mk(1, 8'hA5, 1, 8'hB1, 0, 1, 8'hA4, 0, 0, 0);
    vt[27] = mk(1, 8'hA5, 1, 8'hB1, 1, 1, 8'hB1, 1, 0, 1);
    vt[28] = mk(1, 8'hA5, 1, 8'hB2, 0, 1, 8'hB1, 1, 0, 0);
    vt[29] = mk(0, 8'h00, 0, 8'h00, 1, 1, 8'hA5, 0, 1, 0);
    vt[30] = mk(0, 8'h00, 0, 8'h00, 1, 1, 8'hB2, 1, 1, 1);
    vt[31] = mk(0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 1, 1);

    i_arst = 1'b1; i_en = 1'b0; i_ready = 1'b0;
    i_a_valid = 1'b0; i_a_data = '0; i_b_valid = 1'b0; i_b_data = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_chan", o_channel, 0);
    check("rst_a_ready", o_a_ready, 1);
    check("rst_b_ready", o_b_ready, 1);
    check("rst_tick", o_tick, 0);
    i_arst = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      i_a_valid = vt[i].a_v; i_a_data = vt[i].a_d;
      i_b_valid = vt[i].b_v; i_b_data = vt[i].b_d;
      i_ready   = vt[i].rdy;
      step();
      check($sformatf("v%0d_valid", i), o_valid, vt[i].e_v);
      if (vt[i].e_v) begin
        check($sformatf("v%0d_data", i), o_data, vt[i].e_d);
        check($sformatf("v%0d_chan", i), o_channel, vt[i].e_ch);
      end
      check($sformatf("v%0d_a_ready", i), o_a_ready, vt[i].e_ar);
      check($sformatf("v%0d_b_ready", i), o_b_ready, vt[i].e_br);
    end
    i_a_valid = 1'b0; i_b_valid = 1'b0; i_ready = 1'b1;

    // Continuous enable: pulses in cycles 3, 7, 11 after the rise.
    i_en = 1'b1;
    for (int c = 0; c < 13; c++) begin
      check($sformatf("tick_run_c%0d", c), o_tick, (c == 3 || c == 7 || c == 11) ? 1 : 0);
      step();
    end
    i_en = 1'b0;
    step();

    // Enable dropped in cycle 9: no pulse in cycle 11, and restart counts from 0.
    i_en = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (c == 9) i_en = 1'b0;
      check($sformatf("tick_stop_c%0d", c), o_tick, (c == 3 || c == 7) ? 1 : 0);
      step();
    end
    i_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("tick_restart_c%0d", c), o_tick, (c == 3) ? 1 : 0);
      step();
    end
    i_en = 1'b0;

    // Reset mid-transfer with both holding regs full and a word on the output.
    i_ready = 1'b0;
    i_a_valid = 1'b1; i_a_data = 8'hC1; i_b_valid = 1'b1; i_b_data = 8'hD1;
    step();
    i_a_data = 8'hC2;
    step();
    step();
    check("pre_rst_valid", o_valid, 1);
    check("pre_rst_a_ready", o_a_ready, 0);
    check("pre_rst_b_ready", o_b_ready, 0);
    #2;
    i_arst = 1'b1;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_data", o_data, 0);
    check("arst_chan", o_channel, 0);
    check("arst_a_ready", o_a_ready, 1);
    check("arst_b_ready", o_b_ready, 1);
    i_a_valid = 1'b0; i_b_valid = 1'b0;
    step();
    i_arst = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("post_rst_valid_c%0d", c), o_valid, 0);
    end

    // Fresh traffic after reset starts with A priority (burst cleared).
    i_a_valid = 1'b1; i_a_data = 8'hE1; i_b_valid = 1'b1; i_b_data = 8'hF1;
    step();
    i_a_valid = 1'b0; i_b_valid = 1'b0;
    step();
    check("post_rst_first_data", o_data, 8'hE1);
    check("post_rst_first_chan", o_channel, 0);
    step();
    check("post_rst_second_data", o_data, 8'hF1);
    check("post_rst_second_chan", o_channel, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
